// File: rtl/spi_slave.sv
// spi_slave: SPI peripheral endpoint with oversampled async inputs and AXI-Stream TX/RX ports.
module spi_slave #(
  parameter int AXIS_DATA_WIDTH = 8,
  localparam int WORD_COUNTER_WIDTH = $clog2(AXIS_DATA_WIDTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic                          sclk,
  input  logic                          mosi,
  input  logic                          ss,
  output logic                          miso,
  output logic                          miso_oe,
  input  logic [1:0]                    spi_mode,
  input  logic [WORD_COUNTER_WIDTH-1:0] spi_word_width,
  output logic                          rx_overrun_error,
  output logic                          tx_underrun_error,
  output logic                          bus_active
);
  localparam int W = AXIS_DATA_WIDTH;
  localparam int C = WORD_COUNTER_WIDTH;
  localparam logic [C-1:0] W_MAX = C'(W);
  localparam logic [0:0] IDLE = 1'b0, ACTIVE = 1'b1;
  logic [0:0] state;
  logic [2:0] sclk_s, ss_s;
  logic [1:0] mosi_s;
  logic [1:0] mode_l;
  logic [C-1:0] width_l, width_res, bit_cnt;
  logic [W-1:0] hold_data, tx_sr, rx_sr, rx_next, start_data, top_l, top_res, mask;
  logic hold_valid, lead, trail, sample, shift, ss_fall, ss_rise, done, word_start;
  always_comb begin
    width_res = (spi_word_width == '0 || spi_word_width > W_MAX) ? W_MAX : spi_word_width;
    lead = (sclk_s[1] != mode_l[1]) && (sclk_s[2] == mode_l[1]);
    trail = (sclk_s[1] == mode_l[1]) && (sclk_s[2] != mode_l[1]);
    sample = (state == ACTIVE) && (mode_l[0] ? trail : lead);
    shift = (state == ACTIVE) && (mode_l[0] ? lead : trail);
    ss_fall = !ss_s[1] && ss_s[2];
    ss_rise = ss_s[1] && !ss_s[2];
    rx_next = W'({rx_sr, mosi_s[1]});
    done = sample && !ss_rise && (bit_cnt + 1'b1 == width_l);
    word_start = ((state == IDLE) && ss_fall) || done;
    start_data = hold_valid ? hold_data : '0;
    mask = ~({W{1'b1}} << width_l);
    top_l = {{(W-1){1'b0}}, 1'b1} << (width_l - 1'b1);
    top_res = {{(W-1){1'b0}}, 1'b1} << (width_res - 1'b1);
  end
  assign s_axis_tready = !hold_valid;
  assign bus_active = (state == ACTIVE);
  assign miso_oe = (state == ACTIVE);
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= '0;
      ss_s <= '1;
      mosi_s <= '0;
      state <= IDLE;
      mode_l <= '0;
      width_l <= W_MAX;
      bit_cnt <= '0;
      hold_valid <= 1'b0;
      hold_data <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      miso <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      rx_overrun_error <= 1'b0;
      tx_underrun_error <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      ss_s <= {ss_s[1:0], ss};
      mosi_s <= {mosi_s[0], mosi};
      tx_underrun_error <= word_start && !hold_valid;
      if (word_start && hold_valid) hold_valid <= 1'b0;
      else if (s_axis_tvalid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_data <= s_axis_tdata;
      end
      // A completion always wins over a concurrent accept so the new word is never dropped
      if (done) begin
        m_axis_tdata <= rx_next & mask;
        m_axis_tvalid <= 1'b1;
        if (m_axis_tvalid && !m_axis_tready) rx_overrun_error <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        rx_overrun_error <= 1'b0;
      end
      if (state == IDLE) begin
        if (ss_fall) begin
          state <= ACTIVE;
          mode_l <= spi_mode;
          width_l <= width_res;
          bit_cnt <= '0;
          rx_sr <= '0;
          miso <= spi_mode[0] ? miso : |(start_data & top_res);
          tx_sr <= spi_mode[0] ? start_data : start_data << 1;
        end
      end else if (ss_rise) begin
        state <= IDLE;
        miso <= 1'b0;
      end else begin
        if (sample) begin
          rx_sr <= rx_next;
          bit_cnt <= done ? '0 : bit_cnt + 1'b1;
        end
        // The next word's MSB waits for the following shift edge in both phases
        if (done) tx_sr <= start_data;
        else if (shift) tx_sr <= tx_sr << 1;
        if (shift) miso <= |(tx_sr & top_l);
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed and randomized SPI master stimulus against a word-level reference model.
module tb_spi_slave;
  localparam int H = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] s_axis_tdata = '0, m_axis_tdata;
  logic s_axis_tvalid = 1'b0, s_axis_tready, m_axis_tvalid, m_axis_tready = 1'b0;
  logic sclk = 1'b0, mosi = 1'b0, ss = 1'b1, miso, miso_oe;
  logic [1:0] spi_mode = 2'd0;
  logic [3:0] spi_word_width = 4'd8;
  logic rx_overrun_error, tx_underrun_error, bus_active;
  int total = 0, bad = 0, und_cnt = 0, und_snap = 0;
  logic [7:0] mtx [3];
  logic [7:0] mrx [3];

  spi_slave dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso), .miso_oe(miso_oe),
    .spi_mode(spi_mode), .spi_word_width(spi_word_width),
    .rx_overrun_error(rx_overrun_error), .tx_underrun_error(tx_underrun_error), .bus_active(bus_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (tx_underrun_error) und_cnt <= und_cnt + 1;

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] wmask(input int w);
    return (w >= 8) ? 8'hFF : 8'((1 << w) - 1);
  endfunction

  function automatic int eff_width(input int pin);
    return (pin == 0 || pin > 8) ? 8 : pin;
  endfunction

  task automatic push(input logic [7:0] d);
    int i;
    s_axis_tdata = d;
    s_axis_tvalid = 1'b1;
    for (i = 0; i < 200 && !s_axis_tready; i++) @(negedge clk);
    if (i == 200) chk("push_timeout", 1, 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  // Master side: drives mosi from mtx, captures miso into mrx, optionally aborting after stop_bits
  task automatic xfer(input logic [1:0] mode, input int w, input int nw, input int stop_bits);
    int done_bits;
    logic b;
    done_bits = 0;
    spi_mode = mode;
    sclk = mode[1];
    wclk(4);
    ss = 1'b0;
    wclk(8);
    for (int k = 0; k < nw; k++) begin
      mrx[k] = '0;
      for (int i = w - 1; i >= 0; i--) begin
        if (stop_bits < 0 || done_bits < stop_bits) begin
          b = mtx[k][i[2:0]];
          if (k == nw - 1 && i == 0) und_snap = und_cnt;
          if (!mode[0]) begin
            mosi = b;
            wclk(H);
            mrx[k] = {mrx[k][6:0], miso};
            sclk = ~mode[1];
            wclk(H);
            sclk = mode[1];
          end else begin
            wclk(H);
            sclk = ~mode[1];
            mosi = b;
            wclk(H);
            mrx[k] = {mrx[k][6:0], miso};
            sclk = mode[1];
          end
          done_bits++;
        end
      end
    end
    wclk(H);
    ss = 1'b1;
    mosi = 1'b0;
    wclk(8);
  endtask

  task automatic consume(input string tag, input logic [7:0] exp);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 1);
    chk({tag, "_tdata"}, 32'(m_axis_tdata), 32'(exp));
    m_axis_tready = 1'b1;
    wclk(1);
    m_axis_tready = 1'b0;
    chk({tag, "_drained"}, 32'(m_axis_tvalid), 0);
    chk({tag, "_ovr_clear"}, 32'(rx_overrun_error), 0);
  endtask

  task automatic single(input string tag, input logic [1:0] mode, input int wpin, input logic [7:0] pre, input logic [7:0] sent);
    int w, base;
    w = eff_width(wpin);
    spi_word_width = 4'(wpin);
    push(pre);
    mtx[0] = sent;
    base = und_cnt;
    xfer(mode, w, 1, -1);
    chk({tag, "_miso"}, 32'(mrx[0]), 32'(pre & wmask(w)));
    chk({tag, "_ovr"}, 32'(rx_overrun_error), 0);
    chk({tag, "_und"}, 32'(und_snap - base), 0);
    consume(tag, sent & wmask(w));
  endtask

  initial begin
    int base;
    logic [7:0] a, b;
    wclk(3);
    rst = 1'b0;
    wclk(1);
    chk("rst_miso", 32'(miso), 0);
    chk("rst_oe", 32'(miso_oe), 0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tdata", 32'(m_axis_tdata), 0);
    chk("rst_tready", 32'(s_axis_tready), 1);
    chk("rst_ovr", 32'(rx_overrun_error), 0);
    chk("rst_und", 32'(tx_underrun_error), 0);
    chk("rst_active", 32'(bus_active), 0);

    single("m0", 2'd0, 8, 8'hA5, 8'h3C);
    for (int m = 0; m < 4; m++) single($sformatf("mode%0d", m), 2'(m), 8, 8'h81, 8'h7E);
    single("w5m3", 2'd3, 5, 8'h13, 8'h16);

    // Three words in one select, only two TX words available, downstream stalled
    spi_word_width = 4'd8;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int k = 0; k < 3; k++) mtx[k] = 8'($urandom);
    push(a);
    base = und_cnt;
    fork
      xfer(2'd0, 8, 3, -1);
      begin wclk(20); push(b); end
    join
    chk("b2b_miso0", 32'(mrx[0]), 32'(a));
    chk("b2b_miso1", 32'(mrx[1]), 32'(b));
    chk("b2b_miso2", 32'(mrx[2]), 0);
    chk("b2b_und", 32'(und_snap - base), 1);
    chk("b2b_ovr", 32'(rx_overrun_error), 1);
    consume("b2b", mtx[2]);

    // Select released after 4 of 8 bits
    push(8'hC3);
    mtx[0] = 8'h5A;
    xfer(2'd1, 8, 1, 4);
    chk("abort_tvalid", 32'(m_axis_tvalid), 0);
    chk("abort_oe", 32'(miso_oe), 0);
    chk("abort_active", 32'(bus_active), 0);
    single("post_abort", 2'd1, 8, 8'h96, 8'hE1);

    // Reset during bit 3 with a word still waiting in the holding register
    push(8'hF0);
    mtx[0] = 8'hFF;
    spi_mode = 2'd0;
    sclk = 1'b0;
    wclk(4);
    ss = 1'b0;
    wclk(20);
    push(8'h0F);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1; wclk(H); sclk = 1'b1; wclk(H); sclk = 1'b0;
    end
    wclk(H / 2);
    rst = 1'b1;
    ss = 1'b1;
    mosi = 1'b0;
    wclk(1);
    chk("mid_rst_miso", 32'(miso), 0);
    chk("mid_rst_oe", 32'(miso_oe), 0);
    chk("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("mid_rst_tready", 32'(s_axis_tready), 1);
    chk("mid_rst_active", 32'(bus_active), 0);
    rst = 1'b0;
    wclk(8);
    chk("post_rst_tvalid", 32'(m_axis_tvalid), 0);

    for (int r = 0; r < 6; r++)
      single($sformatf("rnd%0d", r), 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
